rr_trace_reassembler: RTL and testbench

Replay-path front end that turns the fixed-width trace stream read back from trace memory into one packed replay packet per cycle on an `rr_stream_bus_t`-shaped output. That output feeds the trace decoder's demarshaller tree. In trace memory, packets are variable-length and stored back-to-back, LSB first, freely crossing beat boundaries. This block decodes each packet header, computes the packet length, and re-aligns the packet bits (gearbox). It then presents each packet zero-extended to the fixed replay width.

---
 rtl/rr_trace_reassembler.sv | 161 ++++++++++++++++
 tb/tb_rr_trace_reassembler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_trace_reassembler.sv
// rr_trace_reassembler
//
// Replay-path front end. Trace memory holds variable-length packets packed
// back-to-back, LSB first, across fixed-width beats. This block buffers the
// incoming beats, decodes each packet header, works out the packet length,
// and presents one packet per cycle. Each packet is zero-extended to
// OUT_WIDTH.
//
// Packet layout, from the LSB:
//   logb_valid[LOGB_CHANNEL_CNT-1:0]
//   loge_valid[LOGE_CHANNEL_CNT-1:0]
//   data of each channel whose logb_valid bit is set, ascending channel order
//
// An all-zero header marks padding. Padding runs to the end of the current
// source beat.
//
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   in_valid   trace beat valid
//   in_data    trace beat, LSB first
//   in_ready   beat accepted when in_valid && in_ready (depends only on fill)
//   out_valid  packet valid (registered)
//   out_data   packet: logb_valid, loge_valid, compacted data, zero fill
//   out_ready  downstream accepts the packet
//   pkt_cnt    number of packets emitted, wraps modulo 2^32

module rr_trace_reassembler #(
  parameter int LOGB_CHANNEL_CNT      = 4,
  parameter int LOGE_CHANNEL_CNT      = 4,
  parameter int RR_CHANNEL_WIDTH_BITS = 16,
  parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
    {16'd32, 16'd64, 16'd16, 16'd8},
  parameter int IN_WIDTH              = 512,
  localparam int HDR_W     = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
  localparam int OUT_WIDTH = HDR_W + sum_channel_widths(),
  localparam int BUF_W     = OUT_WIDTH + IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic [31:0]          pkt_cnt
);

  // Total payload width if every channel were present.
  function automatic int sum_channel_widths();
    int total;
    total = 0;
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
      total = total + int'(CHANNEL_WIDTHS[i]);
    end
    return total;
  endfunction

  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int OFF_W  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int LEN_W  = $clog2(OUT_WIDTH + 1);
  localparam int OSUM_W = ((OFF_W > LEN_W) ? OFF_W : LEN_W) + 1;

  logic [BUF_W-1:0]     bit_buf;
  logic [FILL_W-1:0]    fill_q;
  logic [OFF_W-1:0]     off_q;

  logic [HDR_W-1:0]     hdr;
  logic [LEN_W-1:0]     pkt_len;
  logic                 accept;
  logic                 can_consume;
  logic                 hdr_present;
  logic                 pad_drop;
  logic                 emit;
  logic [FILL_W-1:0]    consumed;
  logic [FILL_W-1:0]    fill_after;
  logic [BUF_W-1:0]     buf_next;
  logic [OUT_WIDTH-1:0] pkt_bits;
  logic [OSUM_W-1:0]    off_sum;
  logic [OFF_W-1:0]     off_next;

  assign hdr = bit_buf[HDR_W-1:0];

  // Packet length: header plus the width of every channel flagged present.
  always_comb begin
    pkt_len = LEN_W'(HDR_W);
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
      if (hdr[i]) pkt_len = pkt_len + LEN_W'(CHANNEL_WIDTHS[i]);
    end
  end

  // Room for a whole beat is judged on the current fill only. in_ready
  // therefore never waits on out_ready or in_valid.
  assign in_ready    = (fill_q <= FILL_W'(BUF_W - IN_WIDTH));
  assign accept      = in_valid && in_ready;
  assign can_consume = !out_valid || out_ready;
  assign hdr_present = (fill_q >= FILL_W'(HDR_W));

  // The buffer always ends on a source-beat boundary. A present zero header
  // therefore always has its whole beat remainder buffered.
  assign pad_drop = can_consume && hdr_present && (hdr == '0) &&
                    (fill_q >= (FILL_W'(IN_WIDTH) - FILL_W'(off_q)));
  assign emit     = can_consume && hdr_present && (hdr != '0) &&
                    (fill_q >= FILL_W'(pkt_len));

  always_comb begin
    consumed = '0;
    if (pad_drop) begin
      consumed = FILL_W'(IN_WIDTH) - FILL_W'(off_q);
    end else if (emit) begin
      consumed = FILL_W'(pkt_len);
    end
  end

  // Consumption is applied first. A new beat then lands right after the
  // surviving bits. Bits above fill are kept zero, so OR-ing in the beat is
  // safe.
  assign fill_after = fill_q - consumed;
  assign buf_next   = (bit_buf >> consumed) |
                      (accept ? (BUF_W'(in_data) << fill_after) : '0);

  // Clear everything above the packet so the output is zero-extended.
  assign pkt_bits = bit_buf[OUT_WIDTH-1:0] & ~({OUT_WIDTH{1'b1}} << pkt_len);

  // A packet can span more than one beat, so reduce with a true modulo.
  assign off_sum  = OSUM_W'(off_q) + OSUM_W'(pkt_len);
  assign off_next = OFF_W'(off_sum % OSUM_W'(IN_WIDTH));

  // Buffer, head offset and output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_buf   <= '0;
      fill_q    <= '0;
      off_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      pkt_cnt   <= '0;
    end else begin
      if (accept || pad_drop || emit) begin
        bit_buf <= buf_next;
        fill_q  <= fill_after + (accept ? FILL_W'(IN_WIDTH) : '0);
      end

      if (pad_drop) begin
        off_q <= '0;
      end else if (emit) begin
        off_q <= off_next;
      end

      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= pkt_bits;
        pkt_cnt   <= pkt_cnt + 32'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_trace_reassembler.sv
// tb_rr_trace_reassembler
//
// Drives the reassembler with LOGB=2, LOGE=2, channel widths ch0=16 and
// ch1=8, and 32-bit beats (packets up to 28 bits). The bench builds a
// serial bit stream out of abstract packets and chops it into beats. It
// expects each packet back as its own zero-extended word, in order.

module tb_rr_trace_reassembler;

  localparam int IN_W  = 32;
  localparam int OUT_W = 28;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_ready;
  logic [31:0]      pkt_cnt;

  int checks   = 0;
  int failures = 0;
  int sent     = 0;

  logic [IN_W-1:0]  beat_q[$];
  logic [OUT_W-1:0] exp_q[$];
  int first_out;
  int last_out;
  int first_acc;
  int stalls;

  rr_trace_reassembler #(
    .LOGB_CHANNEL_CNT      (2),
    .LOGE_CHANNEL_CNT      (2),
    .RR_CHANNEL_WIDTH_BITS (16),
    .CHANNEL_WIDTHS        ({16'd8, 16'd16}),
    .IN_WIDTH              (IN_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [IN_W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Serialises random packets into a bit stream, inserting padding only
  // where a whole zero header fits before the beat boundary.
  task automatic gen_random(input int npkts);
    bit          bits[$];
    logic [63:0] word;
    logic [1:0]  logb;
    logic [1:0]  loge;
    logic [15:0] d0;
    logic [7:0]  d1;
    logic [IN_W-1:0] w;
    int pos;
    int rem;
    int p;
    p = 0;
    while (p < npkts || ((bits.size() % IN_W) > (IN_W - 4))) begin
      rem = IN_W - (bits.size() % IN_W);
      if (rem != IN_W && rem >= 4 && $urandom_range(3) == 0) begin
        repeat (rem) bits.push_back(1'b0);
        continue;
      end
      logb = 2'($urandom_range(3));
      loge = 2'($urandom_range(3));
      if (logb == 2'b00 && loge == 2'b00) loge = 2'b01;
      d0   = 16'($urandom);
      d1   = 8'($urandom);
      word = 64'(logb) | (64'(loge) << 2);
      pos  = 4;
      if (logb[0]) begin word = word | (64'(d0) << pos); pos = pos + 16; end
      if (logb[1]) begin word = word | (64'(d1) << pos); pos = pos + 8; end
      for (int i = 0; i < pos; i++) bits.push_back(word[i]);
      exp_q.push_back(word[OUT_W-1:0]);
      sent++;
      p++;
    end
    rem = IN_W - (bits.size() % IN_W);
    if (rem != IN_W) repeat (rem) bits.push_back(1'b0);
    for (int b = 0; b < bits.size() / IN_W; b++) begin
      for (int k = 0; k < IN_W; k++) w[k] = bits[b*IN_W + k];
      beat_q.push_back(w);
    end
  endtask

  // Streams beat_q in and checks every output against exp_q, in order.
  task automatic run_stream(input int ready_pct, input int valid_pct, input int budget, input string tag);
    int cyc;
    int bi;
    int nbeats;
    logic v;
    cyc = 0;
    bi = 0;
    nbeats = beat_q.size();
    first_out = -1;
    last_out = -1;
    first_acc = -1;
    stalls = 0;
    while ((bi < nbeats || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      v = (bi < nbeats) && ($urandom_range(99) < valid_pct);
      apply_stimulus(v, v ? beat_q[bi] : IN_W'($urandom), ($urandom_range(99) < ready_pct));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_output({tag, " extra packet"}, 64'(out_data), 64'hdead);
        end else begin
          check_output({tag, " packet"}, 64'(out_data), 64'(exp_q.pop_front()));
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        bi++;
      end
      if (in_valid && !in_ready) stalls++;
      cyc++;
    end
    check_output({tag, " complete"}, 64'((exp_q.size() == 0) && (bi == nbeats)), 64'd1);
    exp_q.delete();
    beat_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply_stimulus(1'b0, IN_W'($urandom), 1'b1);
      check_output({tag, " idle"}, 64'(out_valid), 64'd0);
    end
    check_output({tag, " pkt_cnt"}, 64'(pkt_cnt), 64'(sent));
  endtask

  initial begin
    $display("[TB] start");
    rstn = 1'b0;
    apply_stimulus(1'b0, '0, 1'b1);
    #12;
    check_output("reset out_valid", 64'(out_valid), 64'd0);
    check_output("reset out_data", 64'(out_data), 64'd0);
    check_output("reset pkt_cnt", 64'(pkt_cnt), 64'd0);
    check_output("reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rstn = 1'b1;

    // Single full packet followed by a padding nibble.
    beat_q.push_back(32'h0ABCD127);
    exp_q.push_back(28'hABCD127);
    sent++;
    run_stream(100, 100, 50, "t1 full");
    check_output("t1 latency", 64'(first_out - first_acc), 64'd2);

    // Eight loge-only packets in one beat, one per cycle.
    beat_q.push_back(32'h44444444);
    repeat (8) begin exp_q.push_back(28'h4); sent++; end
    run_stream(100, 100, 50, "t2 loge");
    check_output("t2 latency", 64'(first_out - first_acc), 64'd2);
    check_output("t2 back-to-back", 64'(last_out - first_out), 64'd7);

    // Two loge-only packets, then a 28-bit packet crossing into beat 1.
    beat_q.push_back(32'hBCD12784);
    beat_q.push_back(32'h0000000A);
    exp_q.push_back(28'h4);
    exp_q.push_back(28'h8);
    exp_q.push_back(28'hABCD127);
    sent += 3;
    run_stream(100, 100, 50, "t3 cross");
    check_output("t3 back-to-back", 64'(last_out - first_out), 64'd2);
    check_output("t3 full-buffer stall", 64'(stalls), 64'd1);
    gen_random(1);
    run_stream(100, 100, 50, "t3 realign");

    // Backpressure: hold out_ready low for 10 cycles while beats stream in.
    beat_q.push_back(32'h0ABCD127);
    beat_q.push_back(32'h44444444);
    beat_q.push_back(32'h44444444);
    exp_q.push_back(28'hABCD127);
    repeat (16) exp_q.push_back(28'h4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      apply_stimulus(beat_q.size() > 0, (beat_q.size() > 0) ? beat_q[0] : '0, 1'b0);
      if (out_valid) check_output("t4 hold data", 64'(out_data), 64'hABCD127);
      if (in_valid && in_ready) void'(beat_q.pop_front());
    end
    @(negedge clk);
    apply_stimulus(1'b0, '0, 1'b0);
    check_output("t4 in_ready low", 64'(in_ready), 64'd0);
    check_output("t4 out_valid held", 64'(out_valid), 64'd1);
    check_output("t4 out_data held", 64'(out_data), 64'hABCD127);
    check_output("t4 pkt_cnt held", 64'(pkt_cnt), 64'(sent + 1));
    sent += 17;
    run_stream(100, 100, 100, "t4 release");

    // Asynchronous reset between clock edges with bits still buffered.
    @(negedge clk);
    apply_stimulus(1'b1, 32'h0ABCD127, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    sent++;
    check_output("t5 pre-reset valid", 64'(out_valid), 64'd1);
    check_output("t5 pre-reset pkt_cnt", 64'(pkt_cnt), 64'(sent));
    #2;
    rstn = 1'b0;
    #1;
    check_output("t5 async out_valid", 64'(out_valid), 64'd0);
    check_output("t5 async out_data", 64'(out_data), 64'd0);
    check_output("t5 async pkt_cnt", 64'(pkt_cnt), 64'd0);
    check_output("t5 async in_ready", 64'(in_ready), 64'd1);
    sent = 0;
    @(negedge clk);
    rstn = 1'b1;
    apply_stimulus(1'b0, '0, 1'b1);
    gen_random(12);
    run_stream(80, 80, 2000, "t5 post-reset");

    // Random stress with random valid and ready.
    gen_random(60);
    run_stream(50, 70, 4000, "t6 stress a");
    gen_random(40);
    run_stream(90, 40, 4000, "t6 stress b");
    gen_random(40);
    run_stream(25, 95, 6000, "t6 stress c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
